// File: rtl/phrase_display_driver.sv
// phrase_display_driver: shows a 16-character phrase on an 8-digit seven-segment display, in page or scroll mode
module phrase_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int PAGE_DIV    = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [79:0] phrase,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic        scroll,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        pass_done
);
    localparam int RW = $clog2(REFRESH_DIV + 1);
    localparam int PW = $clog2(PAGE_DIV + 1);

    typedef enum logic [1:0] {IDLE, SHOW, RELOAD} state_t;

    state_t        state, state_n;
    logic [79:0]   phr_q;
    logic [RW-1:0] rcnt;
    logic [PW-1:0] pcnt;
    logic [2:0]    dig;
    logic [3:0]    w, w_n, pos;
    logic [4:0]    code;
    logic          xfer, r_tick, p_wrap, p_tick, hi_blank, show, pass_n;

    function automatic logic [6:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:  glyph = 7'b1000000;
            5'd1:  glyph = 7'b1111001;
            5'd2:  glyph = 7'b0100100;
            5'd3:  glyph = 7'b0110000;
            5'd4:  glyph = 7'b0011001;
            5'd5:  glyph = 7'b0010010;
            5'd6:  glyph = 7'b0000010;
            5'd7:  glyph = 7'b1111000;
            5'd8:  glyph = 7'b0000000;
            5'd9:  glyph = 7'b0010000;
            5'd10: glyph = 7'b0001000;
            5'd11: glyph = 7'b0000011;
            5'd12: glyph = 7'b1000110;
            5'd13: glyph = 7'b0100001;
            5'd14: glyph = 7'b0000110;
            5'd15: glyph = 7'b0001110;
            5'd16: glyph = 7'b1000010;
            5'd17: glyph = 7'b0001001;
            5'd18: glyph = 7'b1001111;
            5'd19: glyph = 7'b1100001;
            5'd20: glyph = 7'b1000111;
            5'd21: glyph = 7'b0101011;
            5'd22: glyph = 7'b0001100;
            5'd23: glyph = 7'b0101111;
            5'd24: glyph = 7'b0000111;
            5'd25: glyph = 7'b1000001;
            5'd26: glyph = 7'b1000011;
            5'd27: glyph = 7'b1110001;
            5'd28: glyph = 7'b0010001;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // A transfer always wins over a same-cycle page tick, so the tick is suppressed then
    assign xfer     = ld_valid && ld_ready;
    assign r_tick   = rcnt == RW'(REFRESH_DIV - 1);
    assign p_wrap   = pcnt == PW'(PAGE_DIV - 1);
    assign p_tick   = state == SHOW && p_wrap && !xfer;
    assign hi_blank = &phr_q[39:0];
    assign pos      = w + 4'd7 - {1'b0, dig};
    assign code     = phr_q[{3'd0, ~pos} * 7'd5 +: 5];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: any transfer goes through a one-cycle reload
    always_comb begin
        state_n = xfer ? RELOAD : state == RELOAD ? SHOW : state;
    end

    // FSM outputs
    always_comb begin
        ld_ready = state != RELOAD;
        show     = state != IDLE;
    end

    // Window offset update on page ticks; misaligned page offsets snap back to 0
    always_comb begin
        w_n    = (xfer || state != SHOW) ? 4'd0 :
                 !p_tick ? w :
                 scroll ? w + 4'd1 :
                 (hi_blank || !(w == 4'd0 || w == 4'd8)) ? 4'd0 : w + 4'd8;
        pass_n = p_tick && w_n == 4'd0 && (w != 4'd0 || (!scroll && hi_blank));
    end

    // Phrase buffer, refresh/page counters, window and pass pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phr_q     <= '1;
            rcnt      <= '0;
            pcnt      <= '0;
            dig       <= '0;
            w         <= '0;
            pass_done <= 1'b0;
        end else begin
            phr_q     <= xfer ? phrase : phr_q;
            rcnt      <= r_tick ? '0 : rcnt + 1'b1;
            dig       <= dig + 3'(r_tick);
            pcnt      <= (state != SHOW || xfer || p_wrap) ? '0 : pcnt + 1'b1;
            w         <= w_n;
            pass_done <= pass_n;
        end
    end

    // Registered segment and anode drive keeps digit changes glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 7'h7F;
            an  <= 8'hFE;
        end else begin
            seg <= show ? glyph(code) : 7'h7F;
            an  <= ~(8'd1 << dig);
        end
    end
endmodule
